redirect_ctrl: RTL and testbench

REDIRECT_CTRL -- requirements
Module: redirect_ctrl

---
 rtl/redirect_ctrl_pkg.sv | 15 +
 rtl/redirect_ctrl_age_cmp.sv | 35 +++
 rtl/redirect_ctrl.sv | 110 +++++++++++
 tb/tb_redirect_ctrl.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/redirect_ctrl_pkg.sv
// Shared defines for the redirect controller: the default PC and ROB id widths
// and the position of the ROB wrap bit.
package redirect_ctrl_pkg;

    localparam int PC_WIDTH_DEF      = 48;
    localparam int ROB_IDX_WIDTH_DEF = 6;

    // The wrap bit sits directly above the index bits of a ROB id.
    function automatic int rob_wrap_pos(input int idx_width);
        return idx_width;
    endfunction

    localparam int ROB_WRAP_POS_DEF = rob_wrap_pos(ROB_IDX_WIDTH_DEF);

endpackage

// File: rtl/redirect_ctrl_age_cmp.sv
// rob_age_cmp: decides whether ROB id A is strictly older than ROB id B.
// Ids are {wrap, idx}. When the wrap bits match, the lower index is older.
// When they differ, B has wrapped past A, so the higher index is older.
// Equal ids are never older.
module rob_age_cmp
    import redirect_ctrl_pkg::*;
#(
    parameter int ROB_IDX_WIDTH = ROB_IDX_WIDTH_DEF
)(
    input  logic [ROB_IDX_WIDTH:0] a_id,
    input  logic [ROB_IDX_WIDTH:0] b_id,
    output logic                   a_older
);

    localparam int WRAP_POS = rob_wrap_pos(ROB_IDX_WIDTH);

    logic                     w_sameWrap;
    logic [ROB_IDX_WIDTH-1:0] w_aIdx;
    logic [ROB_IDX_WIDTH-1:0] w_bIdx;

    assign w_sameWrap = (a_id[WRAP_POS] == b_id[WRAP_POS]);
    assign w_aIdx     = a_id[WRAP_POS-1:0];
    assign w_bIdx     = b_id[WRAP_POS-1:0];

    // Age ordering, with the index compare reversed once the wrap bits differ.
    always_comb begin
        a_older = 1'b0;
        if (w_sameWrap) begin
            a_older = (w_aIdx < w_bIdx);
        end else begin
            a_older = (w_aIdx > w_bIdx);
        end
    end

endmodule

// File: rtl/redirect_ctrl.sv
// redirect_ctrl: holds the oldest outstanding branch redirect, offers it to the
// frontend with a valid/ready handshake, and emits a one-cycle backend kill
// pulse each time a new redirect is captured. An external commit-side flush
// overrides everything.
// Optional build macro: REDIRECT_PERF_CNT_EN adds a 32-bit count of completed
// frontend handshakes on port perf_redirect_cnt.
module redirect_ctrl
    import redirect_ctrl_pkg::*;
#(
    parameter int PC_WIDTH      = PC_WIDTH_DEF,
    parameter int ROB_IDX_WIDTH = ROB_IDX_WIDTH_DEF
)(
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   bju_redirect_valid,
    input  logic [PC_WIDTH-1:0]    bju_redirect_target,
    input  logic [ROB_IDX_WIDTH:0] bju_robid,
    input  logic                   ext_flush_valid,
    input  logic                   fe_redirect_ready,
    output logic                   fe_redirect_valid,
    output logic [PC_WIDTH-1:0]    fe_redirect_target,
    output logic                   flush_valid,
    output logic [ROB_IDX_WIDTH:0] flush_robid
`ifdef REDIRECT_PERF_CNT_EN
    ,
    output logic [31:0]            perf_redirect_cnt
`endif
);

    localparam logic [0:0] STATE_IDLE    = 1'b0;
    localparam logic [0:0] STATE_PENDING = 1'b1;

    logic [0:0]             r_state;
    logic [PC_WIDTH-1:0]    r_target;
    logic [ROB_IDX_WIDTH:0] r_robid;
    logic                   r_flush;

    logic [0:0]             w_nextState;
    logic                   w_capture;
    logic                   w_bjuOlder;
    logic                   w_handshake;

    rob_age_cmp #(
        .ROB_IDX_WIDTH (ROB_IDX_WIDTH)
    ) u_ageCmp (
        .a_id    (bju_robid),
        .b_id    (r_robid),
        .a_older (w_bjuOlder)
    );

    assign fe_redirect_valid  = (r_state == STATE_PENDING);
    assign fe_redirect_target = r_target;
    assign flush_valid        = r_flush;
    assign flush_robid        = r_robid;
    assign w_handshake        = fe_redirect_valid & fe_redirect_ready;

    // Decide the next state and whether this cycle's branch redirect is kept.
    always_comb begin
        w_nextState = r_state;
        w_capture   = 1'b0;
        if (ext_flush_valid) begin
            w_nextState = STATE_IDLE;
        end else if (r_state == STATE_IDLE) begin
            if (bju_redirect_valid) begin
                w_capture   = 1'b1;
                w_nextState = STATE_PENDING;
            end
        end else begin
            if (bju_redirect_valid && w_bjuOlder) begin
                w_capture   = 1'b1;
                w_nextState = STATE_PENDING;
            end else if (w_handshake) begin
                w_nextState = STATE_IDLE;
            end
        end
    end

    // State, held payload and the one-shot kill pulse that follows each capture.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state  <= STATE_IDLE;
            r_target <= '0;
            r_robid  <= '0;
            r_flush  <= 1'b0;
        end else begin
            r_state <= w_nextState;
            r_flush <= w_capture;
            if (w_capture) begin
                r_target <= bju_redirect_target;
                r_robid  <= bju_robid;
            end
        end
    end

`ifdef REDIRECT_PERF_CNT_EN
    logic [31:0] r_perfCnt;

    assign perf_redirect_cnt = r_perfCnt;

    // Count every redirect the frontend accepted; wraps naturally at 2^32.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_perfCnt <= '0;
        end else if (w_handshake) begin
            r_perfCnt <= r_perfCnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_redirect_ctrl.sv
// Directed testbench for redirect_ctrl. Each step drives one cycle of inputs,
// pushes the outputs expected after the next rising edge onto a scoreboard
// queue, then pops and compares once the edge has passed.
module tb_redirect_ctrl;

    localparam int PCW = 48;
    localparam int RIW = 6;

    typedef struct {
        string           tag;
        logic            feValid;
        logic [PCW-1:0]  feTarget;
        logic            flushValid;
        logic [RIW:0]    flushRobid;
    } expect_t;

    logic           clock = 1'b0;
    logic           reset_n;
    logic           bju_redirect_valid;
    logic [PCW-1:0] bju_redirect_target;
    logic [RIW:0]   bju_robid;
    logic           ext_flush_valid;
    logic           fe_redirect_ready;
    logic           fe_redirect_valid;
    logic [PCW-1:0] fe_redirect_target;
    logic           flush_valid;
    logic [RIW:0]   flush_robid;
`ifdef REDIRECT_PERF_CNT_EN
    logic [31:0]    perf_redirect_cnt;
`endif

    int testsRun  = 0;
    int testsFail = 0;
    expect_t scoreboard[$];

    redirect_ctrl #(
        .PC_WIDTH      (PCW),
        .ROB_IDX_WIDTH (RIW)
    ) dut (
        .clock               (clock),
        .reset_n             (reset_n),
        .bju_redirect_valid  (bju_redirect_valid),
        .bju_redirect_target (bju_redirect_target),
        .bju_robid           (bju_robid),
        .ext_flush_valid     (ext_flush_valid),
        .fe_redirect_ready   (fe_redirect_ready),
        .fe_redirect_valid   (fe_redirect_valid),
        .fe_redirect_target  (fe_redirect_target),
        .flush_valid         (flush_valid),
        .flush_robid         (flush_robid)
`ifdef REDIRECT_PERF_CNT_EN
        ,
        .perf_redirect_cnt   (perf_redirect_cnt)
`endif
    );

    // Free-running clock, 10 time units per period.
    always #5 clock = ~clock;

    // One comparison: count it, and on mismatch count and report the failure.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            testsFail++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs, queue the expected outputs, clock, then compare.
    task automatic applyStimulus(input string tag, input logic rstN,
                                 input logic bv, input logic [PCW-1:0] tgt,
                                 input logic [RIW:0] id, input logic ef,
                                 input logic rdy, input logic expV,
                                 input logic [PCW-1:0] expT, input logic expF,
                                 input logic [RIW:0] expId);
        expect_t e;
        expect_t got;
        reset_n             = rstN;
        bju_redirect_valid  = bv;
        bju_redirect_target = tgt;
        bju_robid           = id;
        ext_flush_valid     = ef;
        fe_redirect_ready   = rdy;
        e.tag        = tag;
        e.feValid    = expV;
        e.feTarget   = expT;
        e.flushValid = expF;
        e.flushRobid = expId;
        scoreboard.push_back(e);
        @(posedge clock);
        #1;
        got = scoreboard.pop_front();
        checkOutput({got.tag, ".fe_valid"}, 64'(fe_redirect_valid), 64'(got.feValid));
        checkOutput({got.tag, ".fe_target"}, 64'(fe_redirect_target), 64'(got.feTarget));
        checkOutput({got.tag, ".flush_valid"}, 64'(flush_valid), 64'(got.flushValid));
        checkOutput({got.tag, ".flush_robid"}, 64'(flush_robid), 64'(got.flushRobid));
    endtask

    initial begin
        reset_n             = 1'b0;
        bju_redirect_valid  = 1'b0;
        bju_redirect_target = '0;
        bju_robid           = '0;
        ext_flush_valid     = 1'b0;
        fe_redirect_ready   = 1'b0;
        #2;

        //            tag          rstN bv  target   id     ef  rdy  expV expT     expF expId
        applyStimulus("reset0",    0, 0, 48'h0,    7'h00, 0, 0,   0, 48'h0,    0, 7'h00);
        applyStimulus("reset1",    0, 1, 48'h1234, 7'h11, 0, 0,   0, 48'h0,    0, 7'h00);

        // First capture, then the flush pulse must drop after one cycle.
        applyStimulus("cap05",     1, 1, 48'h1000, 7'h05, 0, 0,   1, 48'h1000, 1, 7'h05);
        applyStimulus("hold05",    1, 0, 48'h0,    7'h00, 0, 0,   1, 48'h1000, 0, 7'h05);

        // Older redirect replaces, younger one is ignored.
        applyStimulus("older03",   1, 1, 48'h2000, 7'h03, 0, 0,   1, 48'h2000, 1, 7'h03);
        applyStimulus("hold03",    1, 0, 48'h0,    7'h00, 0, 0,   1, 48'h2000, 0, 7'h03);
        applyStimulus("young09",   1, 1, 48'h3000, 7'h09, 0, 0,   1, 48'h2000, 0, 7'h03);
        applyStimulus("hs03",      1, 0, 48'h0,    7'h00, 0, 1,   0, 48'h2000, 0, 7'h03);

        // Wrap-bit ordering in both directions.
        applyStimulus("cap3E",     1, 1, 48'h4000, 7'h3E, 0, 0,   1, 48'h4000, 1, 7'h3E);
        applyStimulus("wrap41drop",1, 1, 48'h5000, 7'h41, 0, 0,   1, 48'h4000, 0, 7'h3E);
        applyStimulus("hs3E",      1, 0, 48'h0,    7'h00, 0, 1,   0, 48'h4000, 0, 7'h3E);
        applyStimulus("cap41",     1, 1, 48'h5000, 7'h41, 0, 0,   1, 48'h5000, 1, 7'h41);
        applyStimulus("wrap3Ekeep",1, 1, 48'h4000, 7'h3E, 0, 0,   1, 48'h4000, 1, 7'h3E);
        applyStimulus("hs3Eb",     1, 0, 48'h0,    7'h00, 0, 1,   0, 48'h4000, 0, 7'h3E);

        // Handshake racing a same-cycle redirect.
        applyStimulus("cap05b",    1, 1, 48'h6000, 7'h05, 0, 0,   1, 48'h6000, 1, 7'h05);
        applyStimulus("hsOlder02", 1, 1, 48'h7000, 7'h02, 0, 1,   1, 48'h7000, 1, 7'h02);
        applyStimulus("hsYoung07", 1, 1, 48'h8000, 7'h07, 0, 1,   0, 48'h7000, 0, 7'h02);

        // External flush beats a redirect in IDLE and in PENDING.
        applyStimulus("efIdle",    1, 1, 48'h9000, 7'h01, 1, 0,   0, 48'h7000, 0, 7'h02);
        applyStimulus("cap04",     1, 1, 48'hA000, 7'h04, 0, 0,   1, 48'hA000, 1, 7'h04);
        applyStimulus("efPend",    1, 1, 48'hB000, 7'h01, 1, 0,   0, 48'hA000, 0, 7'h04);

        // Equal id is not older; then reset drops the held redirect.
        applyStimulus("cap10",     1, 1, 48'hC000, 7'h10, 0, 0,   1, 48'hC000, 1, 7'h10);
        applyStimulus("equal10",   1, 1, 48'hD000, 7'h10, 0, 0,   1, 48'hC000, 0, 7'h10);
        applyStimulus("rstPend",   0, 0, 48'h0,    7'h00, 0, 1,   0, 48'h0,    0, 7'h00);
        applyStimulus("postRst",   1, 0, 48'h0,    7'h00, 0, 1,   0, 48'h0,    0, 7'h00);

`ifdef REDIRECT_PERF_CNT_EN
        checkOutput("perfAfterRst", 64'(perf_redirect_cnt), 64'd0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus("perfCap", 1, 1, 48'hE000, 7'h20, 0, 0, 1, 48'hE000, 1, 7'h20);
            applyStimulus("perfHs",  1, 0, 48'h0,    7'h00, 0, 1, 0, 48'hE000, 0, 7'h20);
        end
        checkOutput("perfCnt3", 64'(perf_redirect_cnt), 64'd3);
`endif

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFail);
        $finish;
    end

endmodule
